// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap/mret sequencer.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_EPC,
    S_CAUSE,
    S_TVAL,
    S_STATUS,
    S_MSTAT,
    S_REDIR
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MEIE       = 11;

  localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
  localparam logic [3:0] EXC_BREAK       = 4'd3;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ECALL_M     = 4'd11;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_target_gen.sv
// Redirect target: mtvec base (optionally vectored for interrupts) or mepc for mret.
module trap_target_gen
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic [3:0]      cause,
  input  logic            is_irq,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] target_pc
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;
  logic            unused_mepc_lsbs;

  assign unused_mepc_lsbs = ^mepc[1:0];

  // Modes 10/11 are reserved and fall back to direct.
  always_comb begin
    base   = {mtvec[XLEN-1:2], 2'b00};
    offset = '0;
    if (is_irq && (mtvec[1:0] == MTVEC_VECTORED)) begin
      offset = {{(XLEN-6){1'b0}}, cause, 2'b00};
    end
    if (mret) begin
      target_pc = {mepc[XLEN-1:2], 2'b00};
    end else begin
      target_pc = base + offset;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: flushes ID/EX, stalls the front end, writes the
// trap CSRs one per cycle and issues a single-cycle PC redirect.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IRQ_CAUSE = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_req,
  input  logic            irq_ext,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            trap_flush,
  output logic            stall_front,
  output logic            csr_wr_en,
  output logic [11:0]     csr_wr_addr,
  output logic [XLEN-1:0] csr_wr_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam logic [3:0] IRQ_CODE = 4'(IRQ_CAUSE);

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mcause_word(input logic irq, input logic [3:0] code);
    return {irq, {(XLEN-5){1'b0}}, code};
  endfunction

  state_t          state;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] tval_q;
  logic            is_irq_q;
  logic            irq_pend;
  logic            take_trap;
  logic [XLEN-1:0] acc_epc;
  logic [XLEN-1:0] target_pc;
  logic            unused_bits;

  assign irq_pend  = irq_ext & csr_mstatus[MSTATUS_MIE] & csr_mie[MIE_MEIE] & id_valid;
  assign take_trap = exc_valid | (~mret_req & irq_pend);
  assign acc_epc   = exc_valid ? exc_pc : id_pc;
  assign unused_bits = ^{acc_epc[0], csr_mie[XLEN-1:MIE_MEIE+1], csr_mie[MIE_MEIE-1:0]};

  trap_target_gen #(.XLEN(XLEN)) u_target_gen (
    .mtvec     (csr_mtvec),
    .cause     (cause_q),
    .is_irq    (is_irq_q),
    .mret      (state == S_MSTAT),
    .mepc      (csr_mepc),
    .target_pc (target_pc)
  );

  // Outputs are computed for the state being entered, so each is a plain flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      trap_flush     <= 1'b0;
      stall_front    <= 1'b0;
      busy           <= 1'b0;
      csr_wr_en      <= 1'b0;
      csr_wr_addr    <= '0;
      csr_wr_data    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      trap_flush     <= 1'b0;
      csr_wr_en      <= 1'b0;
      csr_wr_addr    <= '0;
      csr_wr_data    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b1;
      stall_front    <= 1'b1;
      unique case (state)
        IDLE: begin
          busy        <= 1'b0;
          stall_front <= 1'b0;
          if (take_trap) begin
            state       <= S_EPC;
            cause_q     <= exc_valid ? exc_cause : IRQ_CODE;
            tval_q      <= exc_valid ? exc_tval : '0;
            is_irq_q    <= ~exc_valid;
            trap_flush  <= 1'b1;
            csr_wr_en   <= 1'b1;
            csr_wr_addr <= CSR_MEPC;
            csr_wr_data <= {acc_epc[XLEN-1:1], 1'b0};
            busy        <= 1'b1;
            stall_front <= 1'b1;
          end else if (mret_req) begin
            state       <= S_MSTAT;
            trap_flush  <= 1'b1;
            csr_wr_en   <= 1'b1;
            csr_wr_addr <= CSR_MSTATUS;
            csr_wr_data <= mret_mstatus(csr_mstatus);
            busy        <= 1'b1;
            stall_front <= 1'b1;
          end
        end
        S_EPC: begin
          state       <= S_CAUSE;
          csr_wr_en   <= 1'b1;
          csr_wr_addr <= CSR_MCAUSE;
          csr_wr_data <= mcause_word(is_irq_q, cause_q);
        end
        S_CAUSE: begin
          state       <= S_TVAL;
          csr_wr_en   <= 1'b1;
          csr_wr_addr <= CSR_MTVAL;
          csr_wr_data <= tval_q;
        end
        S_TVAL: begin
          state       <= S_STATUS;
          csr_wr_en   <= 1'b1;
          csr_wr_addr <= CSR_MSTATUS;
          csr_wr_data <= trap_mstatus(csr_mstatus);
        end
        S_STATUS, S_MSTAT: begin
          state          <= S_REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= target_pc;
        end
        S_REDIR: begin
          state       <= IDLE;
          busy        <= 1'b0;
          stall_front <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          stall_front <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized and directed bench for trap_sequencer against a cycle-timeline reference model.
module tb_trap_sequencer;
  import trap_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid = 1'b0;
  logic [3:0]  exc_cause = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic        mret_req = 1'b0;
  logic        irq_ext = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic [31:0] csr_mstatus = '0;
  logic [31:0] csr_mie = '0;
  logic [31:0] csr_mtvec = '0;
  logic [31:0] csr_mepc = '0;
  logic        trap_flush;
  logic        stall_front;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  always #5 clk = ~clk;

  trap_sequencer #(.XLEN(32), .IRQ_CAUSE(11)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_req(mret_req), .irq_ext(irq_ext), .id_valid(id_valid), .id_pc(id_pc),
    .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .trap_flush(trap_flush), .stall_front(stall_front), .csr_wr_en(csr_wr_en),
    .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  typedef struct packed {
    logic        flush;
    logic        stall;
    logic        busy;
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
  } snap_t;

  typedef struct packed {
    logic        ev;
    logic [3:0]  ec;
    logic [31:0] epc;
    logic [31:0] etv;
    logic        mret;
    logic        irq;
    logic        idv;
    logic [31:0] idpc;
    logic [31:0] ms;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
  } req_t;

  snap_t obs_s [1:8];
  snap_t exp_s [1:8];
  int tests_run = 0;
  int tests_failed = 0;

  function automatic snap_t snap();
    snap_t s;
    s = {trap_flush, stall_front, busy, csr_wr_en, csr_wr_addr, csr_wr_data, redirect_valid, redirect_pc};
    return s;
  endfunction

  // Reference model: list of CSR writes in architectural order, then one redirect cycle.
  task automatic build_expected(input req_t r);
    logic [11:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] target;
    logic [31:0] code;
    bit          pend;
    bit          is_irq;
    int          n;
    for (int c = 1; c <= 8; c++) exp_s[c] = '0;
    pend = r.irq && r.ms[3] && r.mie[11] && r.idv;
    if (r.ev || (!r.mret && pend)) begin
      is_irq = !r.ev;
      code = r.ev ? 32'(r.ec) : 32'd11;
      wa.push_back(12'h341); wd.push_back((r.ev ? r.epc : r.idpc) & ~32'h1);
      wa.push_back(12'h342); wd.push_back((is_irq ? 32'h8000_0000 : 32'h0) + code);
      wa.push_back(12'h343); wd.push_back(r.ev ? r.etv : 32'h0);
      wa.push_back(12'h300); wd.push_back((r.ms & ~32'h1888) | (((r.ms >> 3) & 32'h1) << 7) | 32'h1800);
      target = (r.mtvec & ~32'h3) + ((is_irq && r.mtvec[1:0] == 2'b01) ? 32'd4 * code : 32'h0);
    end else if (r.mret) begin
      wa.push_back(12'h300);
      wd.push_back((r.ms & ~32'h1888) | (((r.ms >> 7) & 32'h1) << 3) | 32'h80 | 32'h1800);
      target = r.mepc & ~32'h3;
    end else begin
      return;
    end
    n = wa.size();
    for (int c = 1; c <= n; c++) begin
      exp_s[c].we = 1'b1; exp_s[c].addr = wa[c-1]; exp_s[c].data = wd[c-1];
    end
    for (int c = 1; c <= n + 1; c++) begin
      exp_s[c].busy = 1'b1; exp_s[c].stall = 1'b1;
    end
    exp_s[1].flush = 1'b1;
    exp_s[n+1].rv = 1'b1;
    exp_s[n+1].rpc = target;
  endtask

  // Called just after a rising edge; request is accepted on the next edge.
  task automatic drive_and_capture(input req_t r, input int n);
    exc_valid = r.ev; exc_cause = r.ec; exc_pc = r.epc; exc_tval = r.etv;
    mret_req = r.mret; irq_ext = r.irq; id_valid = r.idv; id_pc = r.idpc;
    csr_mstatus = r.ms; csr_mie = r.mie; csr_mtvec = r.mtvec; csr_mepc = r.mepc;
    @(posedge clk); #1;
    exc_valid = 1'b0; mret_req = 1'b0; irq_ext = 1'b0;
    for (int c = 1; c <= 8; c++) obs_s[c] = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs_s[c] = snap();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (snap() !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", snap());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (snap() !== '0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got %h expected 0", snap());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    req_t r;
    r = '0; r.ev = 1'b1; r.ec = EXC_ILLEGAL; r.epc = 32'h0000_0040; r.etv = 32'hFFFF_FFFF;
    r.mtvec = 32'h100; r.ms = 32'h8; r.mie = 32'h800;
    build_expected(r);
    drive_and_capture(r, 7);
    for (int c = 1; c <= 7; c++) begin
      tests_run++;
      if (obs_s[c] !== exp_s[c]) begin
        tests_failed++;
        $display("FAIL illegal cycle %0d: got %h expected %h", c, obs_s[c], exp_s[c]);
      end
    end
    tests_run++;
    if (obs_s[5].rv !== 1'b1 || obs_s[5].rpc !== 32'h100 || obs_s[4].data !== 32'h1880) begin
      tests_failed++;
      $display("FAIL illegal_redirect: got rv=%b pc=%h mstatus=%h expected rv=1 pc=100 mstatus=1880",
               obs_s[5].rv, obs_s[5].rpc, obs_s[4].data);
    end
  endtask

  task automatic test_irq_vectored();
    req_t r;
    r = '0; r.irq = 1'b1; r.ms = 32'h8; r.mie = 32'h800; r.idv = 1'b1; r.idpc = 32'h80;
    r.mtvec = 32'h101;
    build_expected(r);
    drive_and_capture(r, 7);
    for (int c = 1; c <= 7; c++) begin
      tests_run++;
      if (obs_s[c] !== exp_s[c]) begin
        tests_failed++;
        $display("FAIL irq_vectored cycle %0d: got %h expected %h", c, obs_s[c], exp_s[c]);
      end
    end
    tests_run++;
    if (obs_s[2].data !== 32'h8000_000B || obs_s[3].data !== 32'h0 || obs_s[5].rpc !== 32'h12C) begin
      tests_failed++;
      $display("FAIL irq_values: got mcause=%h mtval=%h pc=%h expected 8000000b 0 12c",
               obs_s[2].data, obs_s[3].data, obs_s[5].rpc);
    end
  endtask

  task automatic test_irq_masked();
    req_t r;
    for (int k = 0; k < 2; k++) begin
      r = '0; r.irq = 1'b1; r.mie = 32'h800; r.idpc = 32'h80; r.mtvec = 32'h100;
      r.ms  = (k == 0) ? 32'h0 : 32'h8;
      r.idv = (k == 0) ? 1'b1 : 1'b0;
      build_expected(r);
      drive_and_capture(r, 6);
      for (int c = 1; c <= 6; c++) begin
        tests_run++;
        if (obs_s[c] !== exp_s[c] || obs_s[c].busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL irq_masked%0d cycle %0d: got %h expected %h", k, c, obs_s[c], exp_s[c]);
        end
      end
    end
  endtask

  task automatic test_priority();
    req_t r;
    r = '0; r.ev = 1'b1; r.ec = EXC_ECALL_M; r.epc = 32'h200; r.etv = 32'h0;
    r.mret = 1'b1; r.irq = 1'b1; r.idv = 1'b1; r.idpc = 32'h300;
    r.ms = 32'h88; r.mie = 32'h800; r.mtvec = 32'h401; r.mepc = 32'h500;
    build_expected(r);
    drive_and_capture(r, 7);
    for (int c = 1; c <= 7; c++) begin
      tests_run++;
      if (obs_s[c] !== exp_s[c]) begin
        tests_failed++;
        $display("FAIL priority cycle %0d: got %h expected %h", c, obs_s[c], exp_s[c]);
      end
    end
    tests_run++;
    if (obs_s[2].data !== 32'hB || obs_s[5].rpc !== 32'h400) begin
      tests_failed++;
      $display("FAIL priority_values: got mcause=%h pc=%h expected b 400", obs_s[2].data, obs_s[5].rpc);
    end
  endtask

  task automatic test_mret();
    req_t r;
    r = '0; r.mret = 1'b1; r.ms = 32'h80; r.mepc = 32'h0000_0244; r.mtvec = 32'h100;
    build_expected(r);
    drive_and_capture(r, 4);
    for (int c = 1; c <= 4; c++) begin
      tests_run++;
      if (obs_s[c] !== exp_s[c]) begin
        tests_failed++;
        $display("FAIL mret cycle %0d: got %h expected %h", c, obs_s[c], exp_s[c]);
      end
    end
    tests_run++;
    if (obs_s[1].data !== 32'h1888 || obs_s[2].rpc !== 32'h244 || obs_s[3].busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mret_values: got mstatus=%h pc=%h busy3=%b expected 1888 244 0",
               obs_s[1].data, obs_s[2].rpc, obs_s[3].busy);
    end
  endtask

  task automatic test_reset_mid();
    req_t r;
    r = '0; r.ev = 1'b1; r.ec = EXC_LD_MISALIGN; r.epc = 32'h64; r.etv = 32'h1003;
    r.mtvec = 32'h100; r.ms = 32'h8;
    build_expected(r);
    exc_valid = r.ev; exc_cause = r.ec; exc_pc = r.epc; exc_tval = r.etv;
    csr_mtvec = r.mtvec; csr_mstatus = r.ms; csr_mie = r.mie; csr_mepc = r.mepc;
    mret_req = 1'b0; irq_ext = 1'b0; id_valid = 1'b0; id_pc = '0;
    @(posedge clk); #1;
    exc_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (snap() !== exp_s[c]) begin
        tests_failed++;
        $display("FAIL reset_mid pre cycle %0d: got %h expected %h", c, snap(), exp_s[c]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (snap() !== '0) begin
        tests_failed++;
        $display("FAIL reset_mid abort cycle %0d: got %h expected 0", c, snap());
      end
    end
    @(posedge clk); #1;
    r.ec = EXC_ST_MISALIGN; r.epc = 32'h70; r.etv = 32'h2001;
    build_expected(r);
    drive_and_capture(r, 7);
    for (int c = 1; c <= 7; c++) begin
      tests_run++;
      if (obs_s[c] !== exp_s[c]) begin
        tests_failed++;
        $display("FAIL reset_mid resume cycle %0d: got %h expected %h", c, obs_s[c], exp_s[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    req_t r;
    int   lens [3];
    lens = '{5, 2, 7};
    for (int k = 0; k < 3; k++) begin
      r = '0;
      r.ms = $urandom; r.mie = 32'h800; r.mtvec = $urandom; r.mepc = $urandom;
      r.ec = 4'($urandom_range(15)); r.epc = $urandom; r.etv = $urandom;
      if (k == 1) r.mret = 1'b1;
      else r.ev = 1'b1;
      build_expected(r);
      drive_and_capture(r, lens[k]);
      for (int c = 1; c <= lens[k]; c++) begin
        tests_run++;
        if (obs_s[c] !== exp_s[c]) begin
          tests_failed++;
          $display("FAIL back_to_back req %0d cycle %0d: got %h expected %h", k, c, obs_s[c], exp_s[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    req_t r;
    for (int it = 0; it < 25; it++) begin
      r.ev    = ($urandom_range(2) == 0);
      r.ec    = 4'($urandom_range(15));
      r.epc   = $urandom;
      r.etv   = $urandom;
      r.mret  = ($urandom_range(2) == 0);
      r.irq   = 1'($urandom_range(1));
      r.idv   = 1'($urandom_range(1));
      r.idpc  = $urandom;
      r.ms    = $urandom;
      r.mie   = $urandom;
      r.mtvec = $urandom;
      if ($urandom_range(1) == 1) r.mtvec[1:0] = 2'b01;
      r.mepc  = $urandom;
      build_expected(r);
      drive_and_capture(r, 7);
      for (int c = 1; c <= 7; c++) begin
        tests_run++;
        if (obs_s[c] !== exp_s[c]) begin
          tests_failed++;
          $display("FAIL random it %0d cycle %0d: got %h expected %h", it, c, obs_s[c], exp_s[c]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_illegal();
    test_irq_vectored();
    test_irq_masked();
    test_priority();
    test_mret();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
